// File: rtl/fmuls_acc_if.sv
// fmuls_acc handshake bundle: product beats in, saturated results out.
// The master drives beats and result-ready; the slave (the accumulator) drives results.
interface fmuls_acc_if;
    logic [7:0] i_r1;
    logic [7:0] i_r0;
    logic       i_valid;
    logic       i_last;
    logic       o_ready;
    logic [7:0] o_res_hi;
    logic [7:0] o_res_lo;
    logic       o_sat;
    logic       o_trunc;
    logic [7:0] o_beats;
    logic       o_valid;
    logic       i_ready;

    modport master (
        output i_r1, i_r0, i_valid, i_last, i_ready,
        input  o_ready, o_res_hi, o_res_lo, o_sat, o_trunc, o_beats, o_valid
    );

    modport slave (
        input  i_r1, i_r0, i_valid, i_last, i_ready,
        output o_ready, o_res_hi, o_res_lo, o_sat, o_trunc, o_beats, o_valid
    );
endinterface

// File: rtl/fmuls_acc.sv
// fmuls_acc: reduces a framed burst of Q1.15 products into a wide accumulator
// and reports the sum saturated back to Q1.15 with sat/trunc flags.
module fmuls_acc #(
    parameter int ACC_W     = 24,
    parameter int MAX_BEATS = 16
) (
    input logic        i_clk,
    input logic        i_rst_n,
    fmuls_acc_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] Q_MAX   = {{(ACC_W-16){1'b0}}, 16'h7fff};
    localparam logic signed [ACC_W-1:0] Q_MIN   = {{(ACC_W-16){1'b1}}, 16'h8000};

    state_t                  state;
    logic signed [ACC_W-1:0] acc;
    logic [7:0]              cnt;
    logic                    sticky;
    logic                    rdy;
    logic                    vld;
    logic [15:0]             res;
    logic                    sat;
    logic                    trunc;
    logic [7:0]              beats;

    logic signed [ACC_W-1:0] p;
    logic signed [ACC_W:0]   sum;
    logic                    ovf;
    logic signed [ACC_W-1:0] acc_nx;
    logic [7:0]              cnt_nx;
    logic                    sticky_nx;
    logic                    at_max;
    logic                    accept;
    logic [15:0]             res_nx;
    logic                    clamp_nx;

    assign p      = {{(ACC_W-16){bus.i_r1[7]}}, bus.i_r1, bus.i_r0};
    assign sum    = {acc[ACC_W-1], acc} + {p[ACC_W-1], p};
    assign ovf    = sum[ACC_W] ^ sum[ACC_W-1];
    assign accept = bus.i_valid && rdy;

    // Next accumulator value, beat count and output clamp for an accepted beat.
    always_comb begin
        acc_nx    = p;
        cnt_nx    = 8'd1;
        sticky_nx = 1'b0;
        if (state == ACC) begin
            cnt_nx    = cnt + 8'd1;
            sticky_nx = sticky | ovf;
            if (ovf)
                acc_nx = sum[ACC_W] ? ACC_MIN : ACC_MAX;
            else
                acc_nx = sum[ACC_W-1:0];
        end
        at_max   = (cnt_nx == 8'(MAX_BEATS));
        res_nx   = acc_nx[15:0];
        clamp_nx = 1'b0;
        unique case (1'b1)
            (acc_nx > Q_MAX): begin
                res_nx   = 16'h7fff;
                clamp_nx = 1'b1;
            end
            (acc_nx < Q_MIN): begin
                res_nx   = 16'h8000;
                clamp_nx = 1'b1;
            end
            default: ;
        endcase
    end

    // Frame FSM with registered handshake and result outputs.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state  <= IDLE;
            acc    <= '0;
            cnt    <= '0;
            sticky <= 1'b0;
            rdy    <= 1'b1;
            vld    <= 1'b0;
            res    <= '0;
            sat    <= 1'b0;
            trunc  <= 1'b0;
            beats  <= '0;
        end else begin
            unique case (state)
                IDLE, ACC: begin
                    if (accept) begin
                        acc    <= acc_nx;
                        cnt    <= cnt_nx;
                        sticky <= sticky_nx;
                        if (bus.i_last || at_max) begin
                            state <= DONE;
                            rdy   <= 1'b0;
                            vld   <= 1'b1;
                            res   <= res_nx;
                            sat   <= sticky_nx | clamp_nx;
                            trunc <= !bus.i_last && at_max;
                            beats <= cnt_nx;
                        end else begin
                            state <= ACC;
                        end
                    end
                end
                DONE: begin
                    if (bus.i_ready) begin
                        state <= IDLE;
                        rdy   <= 1'b1;
                        vld   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.o_ready  = rdy;
    assign bus.o_valid  = vld;
    assign bus.o_res_hi = res[15:8];
    assign bus.o_res_lo = res[7:0];
    assign bus.o_sat    = sat;
    assign bus.o_trunc  = trunc;
    assign bus.o_beats  = beats;
endmodule

// File: tb/tb_fmuls_acc.sv
// tb_fmuls_acc: directed frames with hand-computed results; a monitor
// pops expected results from a scoreboard queue on each output handshake.
module tb_fmuls_acc;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   nchk = 0;
    int   nerr = 0;

    typedef struct packed {
        logic [7:0] hi;
        logic [7:0] lo;
        logic       sat;
        logic       trunc;
        logic [7:0] beats;
    } exp_t;

    exp_t sbq[$];

    fmuls_acc_if bus ();

    fmuls_acc #(.ACC_W(24), .MAX_BEATS(16)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int req);
        nchk++;
        if (act != req) begin
            nerr++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic expect_res(input logic [15:0] r, input logic s,
                              input logic t, input logic [7:0] b);
        exp_t e;
        e.hi    = r[15:8];
        e.lo    = r[7:0];
        e.sat   = s;
        e.trunc = t;
        e.beats = b;
        sbq.push_back(e);
    endtask

    // Present one beat and hold it until the DUT accepts it.
    task automatic beat(input logic [15:0] d, input logic last);
        int n;
        n = 0;
        bus.i_valid = 1'b1;
        bus.i_r1    = d[15:8];
        bus.i_r0    = d[7:0];
        bus.i_last  = last;
        @(negedge clk);
        while (!bus.o_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            nchk++;
            nerr++;
            $display("FAIL beat_timeout: actual=stalled required=accept");
        end
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
        bus.i_last  = 1'b0;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.o_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            nchk++;
            nerr++;
            $display("FAIL ready_timeout: actual=0 required=1");
        end
        @(posedge clk);
        #1;
    endtask

    // Result monitor: compare on every output handshake.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.o_valid && bus.i_ready) begin
            if (sbq.size() == 0) begin
                nchk++;
                nerr++;
                $display("FAIL unexpected_result: actual=%02h%02h required=none",
                         bus.o_res_hi, bus.o_res_lo);
            end else begin
                e = sbq.pop_front();
                chk("res_hi", int'(bus.o_res_hi), int'(e.hi));
                chk("res_lo", int'(bus.o_res_lo), int'(e.lo));
                chk("sat",    int'(bus.o_sat),    int'(e.sat));
                chk("trunc",  int'(bus.o_trunc),  int'(e.trunc));
                chk("beats",  int'(bus.o_beats),  int'(e.beats));
            end
        end
    end

    initial begin
        int n;
        bus.i_valid = 1'b0;
        bus.i_last  = 1'b0;
        bus.i_r1    = 8'h00;
        bus.i_r0    = 8'h00;
        bus.i_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_valid", int'(bus.o_valid),  0);
        chk("rst_ready", int'(bus.o_ready),  1);
        chk("rst_hi",    int'(bus.o_res_hi), 0);
        chk("rst_lo",    int'(bus.o_res_lo), 0);
        chk("rst_flags", int'({bus.o_sat, bus.o_trunc}), 0);
        chk("rst_beats", int'(bus.o_beats),  0);
        @(posedge clk);
        #1;

        // Single beat frame, one-cycle latency.
        expect_res(16'h4000, 1'b0, 1'b0, 8'd1);
        beat(16'h4000, 1'b1);
        @(negedge clk);
        chk("lat_valid", int'(bus.o_valid), 1);
        chk("lat_ready", int'(bus.o_ready), 0);

        // Positive and negative output clamps.
        expect_res(16'h7fff, 1'b1, 1'b0, 8'd2);
        beat(16'h4000, 1'b0);
        beat(16'h4000, 1'b1);
        expect_res(16'h8000, 1'b1, 1'b0, 8'd2);
        beat(16'h8000, 1'b0);
        beat(16'h8000, 1'b1);

        // In-range sums.
        expect_res(16'h0000, 1'b0, 1'b0, 8'd2);
        beat(16'h4000, 1'b0);
        beat(16'hc000, 1'b1);
        expect_res(16'h2000, 1'b0, 1'b0, 8'd3);
        beat(16'h2000, 1'b0);
        beat(16'h1000, 1'b0);
        beat(16'hf000, 1'b1);

        // Back-pressure in DONE with a competing beat on the input.
        wait_ready();
        bus.i_ready = 1'b0;
        expect_res(16'h4000, 1'b0, 1'b0, 8'd1);
        beat(16'h4000, 1'b1);
        bus.i_valid = 1'b1;
        bus.i_r1    = 8'h12;
        bus.i_r0    = 8'h34;
        bus.i_last  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_valid", int'(bus.o_valid),  1);
            chk("bp_ready", int'(bus.o_ready),  0);
            chk("bp_hold",  int'({bus.o_res_hi, bus.o_res_lo, bus.o_beats}),
                int'(24'h400001));
            @(posedge clk);
            #1;
        end
        bus.i_valid = 1'b0;
        bus.i_last  = 1'b0;
        bus.i_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("bp_rel_valid", int'(bus.o_valid), 0);
        chk("bp_rel_ready", int'(bus.o_ready), 1);
        @(posedge clk);
        #1;

        // Frame forced closed at 16 beats, then a fresh frame.
        expect_res(16'h0010, 1'b0, 1'b1, 8'd16);
        for (int i = 0; i < 16; i++) beat(16'h0001, 1'b0);
        expect_res(16'h0001, 1'b0, 1'b0, 8'd1);
        beat(16'h0001, 1'b1);

        // Reset mid-frame discards partial sum.
        wait_ready();
        beat(16'h4000, 1'b0);
        beat(16'h4000, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_valid", int'(bus.o_valid), 0);
        chk("mid_rst_ready", int'(bus.o_ready), 1);
        @(posedge clk);
        #1;
        expect_res(16'h0100, 1'b0, 1'b0, 8'd1);
        beat(16'h0100, 1'b1);

        n = 0;
        while (sbq.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        chk("drain", sbq.size(), 0);
        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule

// File: doc/fmuls_acc.md
Name: fmuls_acc

Overview:
- Sequential accumulator directly downstream of the FMULS stage; consumes its signed Q1.15 product, delivered as the r1:r0 byte pair.
- Sums a framed burst of products into a wide accumulator.
- At frame end, saturates the sum back to Q1.15 and presents it as an r1:r0 pair with flags.
- Valid/ready handshakes on both sides; it is the dot-product/FIR reduction stage after the fractional multiplier.

Parameters:
- ACC_W, 24: accumulator width in bits (signed, two's complement, ≥17).
- MAX_BEATS, 16: maximum products per frame before a forced frame end (1..255).

Ports:
- i_clk  in  1  clock; everything updates on its rising edge.
- i_rst_n  in  1  reset; one clock; reset is synchronous and active-low.
- i_r1  in  8  product high byte (FMULS r1).
- i_r0  in  8  product low byte (FMULS r0).
- i_valid  in  1  product beat valid.
- i_last  in  1  marks final beat of frame; qualified by i_valid.
- o_ready  out  1  block can accept a beat.
- o_res_hi  out  8  saturated result high byte.
- o_res_lo  out  8  saturated result low byte.
- o_sat  out  1  result was clamped, either at output or in the accumulator.
- o_trunc  out  1  frame forced closed at MAX_BEATS without i_last.
- o_beats  out  8  number of beats in the reported frame.
- o_valid  out  1  result valid.
- i_ready  in  1  downstream accepts result.

Behaviour:
- Reset (i_rst_n=0 at clock edge):
  - State goes to IDLE; acc=0, beat count=0.
  - o_valid=0, o_ready=1, o_res_hi/lo=0x00, o_sat=0, o_trunc=0, o_beats=0.
  - Reset overrides any simultaneous handshake.
  - Reset mid-frame or in DONE discards all partial data; the next beat after release starts a new frame.
- Beat accept:
  - A beat is accepted on a clock edge where i_valid=1 and o_ready=1.
  - p = signed {i_r1,i_r0}, sign-extended to ACC_W.
- States:
  - IDLE:
    - o_ready=1.
    - On accept: acc<=p, count<=1, sticky sat<=0.
    - Go DONE if i_last=1 or MAX_BEATS=1; else go ACC.
  - ACC:
    - o_ready=1.
    - On accept: acc<=sat_add(acc,p), count<=count+1.
    - Go DONE if i_last=1 or count+1=MAX_BEATS. trunc=1 when the count limit closes the frame without i_last.
    - No accept: hold.
  - DONE:
    - o_ready=0; i_valid ignored, no beats lost from the block's view because the producer must hold.
    - o_valid=1; result outputs stable and registered.
    - On i_ready=1: next cycle IDLE, o_valid=0, o_ready=1. The result outputs hold their last values until the next DONE.
    - o_valid never drops without i_ready.
- sat_add: full-precision sum of acc and p. On ACC_W overflow, clamp to the ACC_W max or min and set sticky sat.
- Output saturation on entry to DONE:
  - acc > 32767 → 0x7FFF, sat=1.
  - acc < −32768 → 0x8000, sat=1.
  - Otherwise acc[15:0].
  - o_res_hi = bits 15:8, o_res_lo = bits 7:0.
- o_beats = frame beat count. o_sat = sticky sat OR output clamp. o_trunc as defined above.
- Latency: o_valid rises on the clock edge after the last beat is accepted (one cycle). Maximum throughput is one beat per cycle, plus a minimum one-cycle DONE bubble per frame.
- i_last without i_valid has no effect.
- i_ready while o_valid=0 has no effect.

Test Plan:
- Reset, then single beat r1:r0=0x40:0x00, i_last=1 → next cycle o_valid=1, res 0x40/0x00, o_sat=0, o_trunc=0, o_beats=1, o_ready=0.
- Beats 0x4000, 0x4000 (last) → sum 32768 → res 0x7F/0xFF, o_sat=1, o_beats=2; beats 0x8000, 0x8000 → res 0x80/0x00, o_sat=1.
- Beats 0x4000, 0xC000 (last) → res 0x00/0x00, o_sat=0; beats 0x2000, 0x1000, 0xF000 → res 0x20/0x00, o_beats=3.
- Back-pressure: in DONE hold i_ready=0 for 3 cycles while i_valid=1 with other data → outputs unchanged, o_ready=0, no accumulation; i_ready=1 → o_valid=0, o_ready=1 next cycle.
- MAX_BEATS=16: 16 beats of 0x0001, i_last never asserted → res 0x00/0x10, o_trunc=1, o_beats=16; 17th beat starts a new frame.
- Reset low for one cycle after 2 accepted beats of 0x4000 → o_valid=0, o_ready=1; then beat 0x0100 (last) → res 0x01/0x00, o_beats=1.
